// File: rtl/pin_pkg.sv
// Shared sizes, limits and state encoding for the PIN entry block.
package pin_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned PIN_W      = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W      = 3;

    localparam logic [DIGIT_W-1:0] BCD_MAX = DIGIT_W'(9);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SUBMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Shift-register button debouncer producing a clean level and a one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEB_LEN = 4
) (
    input  logic clk_500Hz,
    input  logic btnR,
    input  logic raw,
    output logic level,
    output logic press
);

    logic [DEB_LEN-1:0] shift;
    logic               level_q;

    // Level only changes once the whole window agrees; mixed samples hold it.
    always_ff @(posedge clk_500Hz or posedge btnR) begin
        if (btnR) begin
            shift   <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            shift <= {shift[DEB_LEN-2:0], raw};
            if (&shift) begin
                level <= 1'b1;
            end else if (~|shift) begin
                level <= 1'b0;
            end
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/pin_entry.sv
// Collects a BCD PIN digit by digit and strobes it out once complete.
module pin_entry
    import pin_pkg::*;
#(
    parameter int unsigned DEB_LEN     = 4,
    parameter int unsigned TIMEOUT_CYC = 2500
) (
    input  logic               clk_500Hz,
    input  logic               btnR,
    input  logic [DIGIT_W-1:0] sw,
    input  logic               btnC,
    input  logic               btnL,
    output logic [PIN_W-1:0]   userPin,
    output logic               validPin,
    output logic [CNT_W-1:0]   digitCount,
    output logic               badDigit,
    output logic               timedOut
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic             ent_press;
    logic             clr_press;
    logic             ent_level_unused;
    logic             clr_level_unused;
    logic             timeout_hit;
    logic             digit_ok;

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_enter (
        .clk_500Hz (clk_500Hz),
        .btnR      (btnR),
        .raw       (btnC),
        .level     (ent_level_unused),
        .press     (ent_press)
    );

    btn_debounce #(.DEB_LEN(DEB_LEN)) u_deb_clear (
        .clk_500Hz (clk_500Hz),
        .btnR      (btnR),
        .raw       (btnL),
        .level     (clr_level_unused),
        .press     (clr_press)
    );

    assign timeout_hit = (state == ST_COLLECT) && (tmr == TMR_W'(TIMEOUT_CYC - 1));
    assign digit_ok    = (sw <= BCD_MAX);

    // Priority: SUBMIT swallows presses, then clear, then timeout, then digit entry.
    always_ff @(posedge clk_500Hz or posedge btnR) begin
        if (btnR) begin
            state      <= ST_IDLE;
            userPin    <= '0;
            validPin   <= 1'b0;
            digitCount <= '0;
            badDigit   <= 1'b0;
            timedOut   <= 1'b0;
            tmr        <= '0;
        end else begin
            validPin <= 1'b0;
            badDigit <= 1'b0;
            timedOut <= 1'b0;
            if (state == ST_COLLECT) begin
                tmr <= tmr + TMR_W'(1);
            end

            if (state == ST_SUBMIT) begin
                state <= ST_IDLE;
            end else if (clr_press || timeout_hit) begin
                state      <= ST_IDLE;
                userPin    <= '0;
                digitCount <= '0;
                tmr        <= '0;
                timedOut   <= ~clr_press;
            end else if (ent_press) begin
                if (!digit_ok) begin
                    badDigit <= 1'b1;
                end else begin
                    tmr <= '0;
                    if (state == ST_IDLE) begin
                        userPin <= PIN_W'(sw);
                    end else begin
                        userPin <= {userPin[PIN_W-DIGIT_W-1:0], sw};
                    end
                    if (digitCount == CNT_W'(NUM_DIGITS - 1)) begin
                        state      <= ST_SUBMIT;
                        digitCount <= '0;
                        validPin   <= 1'b1;
                    end else begin
                        state      <= ST_COLLECT;
                        digitCount <= digitCount + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pin_entry.sv
// Scoreboard bench for pin_entry: directed scenarios followed by randomized button traffic.
module tb_pin_entry;

    localparam int DEB = 4;
    localparam int TO  = 20;

    logic        clk = 1'b0;
    logic        btnR = 1'b1;
    logic [3:0]  sw = 4'd0;
    logic        btnC = 1'b0;
    logic        btnL = 1'b0;
    logic [15:0] userPin;
    logic        validPin;
    logic [2:0]  digitCount;
    logic        badDigit;
    logic        timedOut;

    pin_entry #(.DEB_LEN(DEB), .TIMEOUT_CYC(TO)) dut (
        .clk_500Hz  (clk),
        .btnR       (btnR),
        .sw         (sw),
        .btnC       (btnC),
        .btnL       (btnL),
        .userPin    (userPin),
        .validPin   (validPin),
        .digitCount (digitCount),
        .badDigit   (badDigit),
        .timedOut   (timedOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 valid, 1 bad digit, 2 timeout
        logic [15:0] pin;
        int          cnt;
        int          t;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: digits entered so far and time of the last accepted digit
    logic [15:0] m_pin = 16'h0;
    int          m_cnt = 0;
    bit          m_collect = 1'b0;
    int          m_acc_t = 0;
    int          m_before = 0;

    bit lat_on = 1'b0;
    int lat_p = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    function automatic void push_exp(int k, logic [15:0] p, int c, int t);
        ev_t e;
        e.kind = k; e.pin = p; e.cnt = c; e.t = t;
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear();
        m_pin = 16'h0; m_cnt = 0; m_collect = 1'b0;
    endfunction

    function automatic void model_timeout_upto(int t);
        if (m_collect && (m_acc_t + TO <= t)) begin
            push_exp(2, 16'h0, 0, m_acc_t + TO);
            model_clear();
        end
    endfunction

    // kind: 0 = enter digit, 1 = clear, 2 = both buttons together; p = action cycle
    function automatic void model_press(int kind, logic [3:0] d, int p);
        model_timeout_upto(p - 1);
        m_before = m_cnt;
        if (m_collect && (m_acc_t + TO == p)) begin
            if (kind == 0) push_exp(2, 16'h0, 0, p);
            model_clear();
            return;
        end
        if (kind != 0) begin
            model_clear();
            return;
        end
        if (d > 4'd9) begin
            push_exp(1, m_pin, m_cnt, p);
            return;
        end
        m_pin = (m_cnt == 0) ? {12'h0, d} : {m_pin[11:0], d};
        m_cnt++;
        if (m_cnt == 4) begin
            push_exp(0, m_pin, 0, p);
            m_cnt = 0;
            m_collect = 1'b0;
        end else begin
            m_collect = 1'b1;
            m_acc_t = p;
        end
    endfunction

    // Monitor: record every strobe, then match observed against expected in order
    always @(negedge clk) begin
        int  n;
        ev_t o, e;
        if (!btnR) begin
            n = int'(validPin) + int'(badDigit) + int'(timedOut);
            if (n != 0) begin
                check("strobe_exclusive", int'(n > 1), 0);
                o.kind = validPin ? 0 : (badDigit ? 1 : 2);
                o.pin  = userPin;
                o.cnt  = int'(digitCount);
                o.t    = cyc;
                obs_q.push_back(o);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check("ev_kind", o.kind, e.kind);
            check("ev_pin", int'(o.pin), int'(e.pin));
            check("ev_count", o.cnt, e.cnt);
            check("ev_time", o.t, e.t);
        end
    end

    task automatic tick();
        @(negedge clk);
        if (lat_on) begin
            if (cyc == lat_p - 1) check("count_before_action", int'(digitCount), m_before);
            if (cyc == lat_p)     check("count_after_action", int'(digitCount), m_cnt);
        end
    endtask

    task automatic set_btns(int kind, bit v);
        btnC = (kind != 1) && v;
        btnL = (kind != 0) && v;
    endtask

    task automatic do_op(int kind, logic [3:0] d, int bounce, int hold, int low);
        int rise;
        sw = d;
        for (int i = 0; i < 2 * bounce; i++) begin
            set_btns(kind, (i % 2) == 0);
            tick();
        end
        set_btns(kind, 1'b1);
        rise = cyc;
        model_press(kind, d, rise + DEB + 2);
        lat_p = rise + DEB + 2;
        lat_on = 1'b1;
        repeat (hold) tick();
        set_btns(kind, 1'b0);
        repeat (low) tick();
        lat_on = 1'b0;
        model_timeout_upto(cyc);
        check("op_pin", int'(userPin), int'(m_pin));
        check("op_count", int'(digitCount), m_cnt);
    endtask

    task automatic digit(logic [3:0] d);
        do_op(0, d, 0, 6, 6);
    endtask

    initial begin
        int r, kind, low;
        logic [3:0] d;

        repeat (3) @(negedge clk);
        check("rst_pin", int'(userPin), 0);
        check("rst_count", int'(digitCount), 0);
        check("rst_valid", int'(validPin), 0);
        check("rst_bad", int'(badDigit), 0);
        check("rst_timeout", int'(timedOut), 0);
        btnR = 1'b0;
        repeat (2) tick();

        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        check("t1_pin", int'(userPin), 16'h1234);
        check("t1_count", int'(digitCount), 0);

        digit(4'hA);
        check("t2_bad_count", int'(digitCount), 0);
        digit(4'd5); digit(4'd6); digit(4'd7); digit(4'd8);
        check("t2_pin", int'(userPin), 16'h5678);

        do_op(0, 4'd3, 5, 8, 6);
        check("t3_count", int'(digitCount), 1);

        digit(4'd2); digit(4'd7);
        do_op(1, 4'd0, 0, 6, 6);
        check("t4_clr_pin", int'(userPin), 0);
        check("t4_clr_count", int'(digitCount), 0);
        digit(4'd9); digit(4'd9); digit(4'd9); digit(4'd9);
        check("t4_pin", int'(userPin), 16'h9999);

        do_op(0, 4'd4, 0, 6, 30);
        check("t5_pin", int'(userPin), 0);
        check("t5_count", int'(digitCount), 0);

        digit(4'd1); digit(4'd2); digit(4'd3);
        #2 btnR = 1'b1;
        #1;
        check("t6_async_pin", int'(userPin), 0);
        check("t6_async_count", int'(digitCount), 0);
        model_clear();
        tick();
        btnR = 1'b0;
        repeat (2) tick();
        digit(4'd9); digit(4'd8); digit(4'd7); digit(4'd6);
        check("t6_pin", int'(userPin), 16'h9876);

        digit(4'd3);
        do_op(2, 4'd5, 0, 6, 6);
        check("both_count", int'(digitCount), 0);

        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 15));
            kind = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            d = (r < 4) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            low = (r == 15) ? 25 : int'($urandom_range(5, 9));
            do_op(kind, d, int'($urandom_range(0, 4)), int'($urandom_range(5, 8)), low);
        end

        repeat (30) tick();
        model_timeout_upto(cyc);
        repeat (3) tick();
        check("exp_drained", exp_q.size(), 0);
        check("obs_drained", obs_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
